// File: rtl/mem_access_unit.sv
// M-stage load/store unit: alignment checks, byte-lane steering and a
// single-outstanding request/data handshake to the data bus.
module mem_access_unit #(
   parameter int BIG_ENDIAN = 1,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [3:0]        mem_op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic              flush,
   output logic              stall,
   output logic              done,
   output logic [31:0]       rdata_o,
   output logic              adel,
   output logic              ades,
   output logic [ADDR_W-1:0] badvaddr,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [31:0]       mem_rdata
);
   localparam int NUM_LANES = 4;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

   typedef struct packed {
      logic [3:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } memReq_t;

   function automatic logic isValidOp(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd8);
   endfunction

   function automatic logic isStoreOp(input logic [3:0] op);
      return (op >= 4'd6) && (op <= 4'd8);
   endfunction

   function automatic logic [1:0] opSize(input logic [3:0] op);
      case (op)
         4'd1, 4'd2, 4'd6: return 2'd0;
         4'd3, 4'd4, 4'd7: return 2'd1;
         default:          return 2'd2;
      endcase
   endfunction

   function automatic logic isAligned(input logic [1:0] size, input logic [1:0] offs);
      case (size)
         2'd1:    return ~offs[0];
         2'd2:    return offs == 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   state_t  state, stateNxt;
   memReq_t cur;
   logic    accept, loadCapture;

   logic inValid, inAligned, inLegal;
   assign inValid   = req_valid && isValidOp(mem_op);
   assign inAligned = isAligned(opSize(mem_op), addr[1:0]);
   assign inLegal   = inValid && inAligned;

   logic [1:0]           curSize, curOffs;
   logic [2:0]           curBytes;
   logic [NUM_LANES-1:0] laneHit;
   assign curSize  = opSize(cur.op);
   assign curOffs  = cur.addr[1:0];
   assign curBytes = 3'd1 << curSize;

   // Each lane owns one byte offset; it is strobed when that offset falls inside the access.
   for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
      localparam logic [2:0] LANE_OFF = 3'((BIG_ENDIAN != 0) ? NUM_LANES - 1 - i : i);
      assign laneHit[i] = (LANE_OFF >= {1'b0, curOffs}) &&
                          (LANE_OFF <  ({1'b0, curOffs} + curBytes));
   end

   logic [NUM_LANES-1:0][7:0] rdLane;
   logic [1:0]                bSel, hHi, hLo;
   logic [7:0]                byteV;
   logic [15:0]               halfV;
   logic [31:0]               loadVal;

   // Big-endian lane index is 3-offset, which is the bitwise inverse of a 2-bit offset.
   assign rdLane = mem_rdata;
   assign bSel   = (BIG_ENDIAN != 0) ? ~curOffs : curOffs;
   assign hHi    = (BIG_ENDIAN != 0) ? ~curOffs : (curOffs | 2'd1);
   assign hLo    = (BIG_ENDIAN != 0) ? ~(curOffs | 2'd1) : curOffs;
   assign byteV  = rdLane[bSel];
   assign halfV  = {rdLane[hHi], rdLane[hLo]};

   always_comb begin
      case (cur.op)
         4'd1:    loadVal = {{24{byteV[7]}}, byteV};
         4'd2:    loadVal = {24'd0, byteV};
         4'd3:    loadVal = {{16{halfV[15]}}, halfV};
         4'd4:    loadVal = {16'd0, halfV};
         default: loadVal = mem_rdata;
      endcase
   end

   always_comb begin
      case (curSize)
         2'd0:    mem_wdata = {4{cur.wdata[7:0]}};
         2'd1:    mem_wdata = {2{cur.wdata[15:0]}};
         default: mem_wdata = cur.wdata;
      endcase
   end

   always_comb begin
      stateNxt    = state;
      accept      = 1'b0;
      loadCapture = 1'b0;
      stall       = 1'b0;
      done        = 1'b0;
      adel        = 1'b0;
      ades        = 1'b0;
      mem_req     = 1'b0;
      case (state)
         IDLE: begin
            if (inValid && !flush) begin
               if (inAligned) begin
                  accept   = 1'b1;
                  stall    = 1'b1;
                  stateNxt = REQ;
               end else if (isStoreOp(mem_op)) begin
                  ades = 1'b1;
               end else begin
                  adel = 1'b1;
               end
            end
         end
         REQ: begin
            mem_req = 1'b1;
            stall   = 1'b1;
            if (flush)            stateNxt = mem_addr_ok ? DRAIN : IDLE;
            else if (mem_addr_ok) stateNxt = WAIT;
         end
         WAIT: begin
            stall = 1'b1;
            if (mem_data_ok) begin
               // Data landing together with a flush leaves nothing to drain.
               stateNxt    = flush ? IDLE : DONE;
               loadCapture = !flush && !isStoreOp(cur.op);
            end else if (flush) begin
               stateNxt = DRAIN;
            end
         end
         DONE: begin
            done     = 1'b1;
            stateNxt = IDLE;
         end
         DRAIN: begin
            stall = inLegal;
            if (mem_data_ok) stateNxt = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
      if (rst) begin
         stall   = 1'b0;
         done    = 1'b0;
         adel    = 1'b0;
         ades    = 1'b0;
         mem_req = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cur     <= '0;
         rdata_o <= '0;
      end else begin
         state <= stateNxt;
         if (accept)      cur     <= '{op: mem_op, addr: addr, wdata: wdata};
         if (loadCapture) rdata_o <= loadVal;
      end
   end

   assign mem_wr    = isStoreOp(cur.op);
   assign mem_size  = curSize;
   assign mem_addr  = cur.addr;
   assign mem_wstrb = (mem_req && isStoreOp(cur.op)) ? laneHit : '0;
   assign badvaddr  = addr;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a big-endian and a little-endian instance
// share stimulus and are both checked every cycle against a transaction-level model.
module tb_mem_access_unit;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst, req_valid, flush, mem_addr_ok, mem_data_ok;
   logic [3:0]    mem_op;
   logic [AW-1:0] addr;
   logic [31:0]   wdata, mem_rdata;

   // index 0 = big-endian instance, 1 = little-endian instance
   logic [1:0]    stall, done, adel, ades, mem_req, mem_wr;
   logic [AW-1:0] badvaddr[2], mem_addr[2];
   logic [31:0]   rdata_o[2], mem_wdata[2];
   logic [1:0]    mem_size[2];
   logic [3:0]    mem_wstrb[2];

   mem_access_unit #(.BIG_ENDIAN(1), .ADDR_W(AW)) dutBe (
      .clk(clk), .rst(rst), .req_valid(req_valid), .mem_op(mem_op), .addr(addr),
      .wdata(wdata), .flush(flush), .stall(stall[0]), .done(done[0]),
      .rdata_o(rdata_o[0]), .adel(adel[0]), .ades(ades[0]), .badvaddr(badvaddr[0]),
      .mem_req(mem_req[0]), .mem_wr(mem_wr[0]), .mem_size(mem_size[0]),
      .mem_addr(mem_addr[0]), .mem_wstrb(mem_wstrb[0]), .mem_wdata(mem_wdata[0]),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata));

   mem_access_unit #(.BIG_ENDIAN(0), .ADDR_W(AW)) dutLe (
      .clk(clk), .rst(rst), .req_valid(req_valid), .mem_op(mem_op), .addr(addr),
      .wdata(wdata), .flush(flush), .stall(stall[1]), .done(done[1]),
      .rdata_o(rdata_o[1]), .adel(adel[1]), .ades(ades[1]), .badvaddr(badvaddr[1]),
      .mem_req(mem_req[1]), .mem_wr(mem_wr[1]), .mem_size(mem_size[1]),
      .mem_addr(mem_addr[1]), .mem_wstrb(mem_wstrb[1]), .mem_wdata(mem_wdata[1]),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit checkEn = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference rules ----------------
   function automatic int nBytes(input logic [3:0] op);
      if (op == 1 || op == 2 || op == 6) return 1;
      if (op == 3 || op == 4 || op == 7) return 2;
      return 4;
   endfunction

   function automatic bit isValid(input logic [3:0] op);
      return op >= 1 && op <= 8;
   endfunction

   function automatic bit isSt(input logic [3:0] op);
      return op >= 6 && op <= 8;
   endfunction

   function automatic bit aligned(input logic [3:0] op, input logic [31:0] a);
      return (a % nBytes(op)) == 0;
   endfunction

   function automatic logic [1:0] expSize(input logic [3:0] op);
      int n;
      n = nBytes(op);
      return (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
   endfunction

   // little-endian: offset k is strobe bit k; big-endian mirrors it
   function automatic logic [3:0] expStrb(input logic [3:0] op, input logic [31:0] a, input bit be);
      int n, off;
      logic [3:0] m, r;
      n = nBytes(op);
      off = a % 4;
      m = 4'(((1 << n) - 1) << off);
      for (int i = 0; i < 4; i++) r[i] = m[3-i];
      return be ? r : m;
   endfunction

   function automatic logic [31:0] expWd(input logic [3:0] op, input logic [31:0] wd);
      int n;
      n = nBytes(op);
      if (n == 1) return {4{wd[7:0]}};
      if (n == 2) return {2{wd[15:0]}};
      return wd;
   endfunction

   function automatic logic [31:0] expLoad(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] word, input bit be);
      int n, off, low;
      logic [31:0] v;
      n = nBytes(op);
      off = a % 4;
      low = be ? 8 * (4 - off - n) : 8 * off;
      v = word >> low;
      case (op)
         1: v = {{24{v[7]}}, v[7:0]};
         2: v = {24'd0, v[7:0]};
         3: v = {{16{v[15]}}, v[15:0]};
         4: v = {16'd0, v[15:0]};
         default: ;
      endcase
      return v;
   endfunction

   // ---------------- transaction-level model ----------------
   bit          busy, accepted, cancelled, finishing;
   logic [3:0]  mOp;
   logic [31:0] mAddr, mWd;
   logic [31:0] expRd[2];

   initial begin
      busy = 0; accepted = 0; cancelled = 0; finishing = 0;
      mOp = 0; mAddr = 0; mWd = 0; expRd[0] = 0; expRd[1] = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            busy = 0; accepted = 0; cancelled = 0; finishing = 0;
            mOp = 0; mAddr = 0; mWd = 0; expRd[0] = 0; expRd[1] = 0;
         end else if (finishing) begin
            finishing = 0;
         end else if (!busy) begin
            if (req_valid && isValid(mem_op) && aligned(mem_op, addr) && !flush) begin
               busy = 1; accepted = 0; cancelled = 0;
               mOp = mem_op; mAddr = addr; mWd = wdata;
            end
         end else if (!accepted) begin
            if (mem_addr_ok) begin
               accepted = 1;
               cancelled = flush;
            end else if (flush) begin
               busy = 0;
            end
         end else if (!cancelled) begin
            if (mem_data_ok) begin
               busy = 0;
               if (!flush) begin
                  finishing = 1;
                  if (!isSt(mOp)) begin
                     expRd[0] = expLoad(mOp, mAddr, mem_rdata, 1);
                     expRd[1] = expLoad(mOp, mAddr, mem_rdata, 0);
                  end
               end
            end else if (flush) begin
               cancelled = 1;
            end
         end else if (mem_data_ok) begin
            busy = 0;
         end
      end
   end

   task automatic cmpDut(input int k, input bit eStall, eDone, eAdel, eAdes, eReq);
      string t;
      t = (k == 0) ? "be" : "le";
      chk({t, ".stall"}, stall[k], eStall);
      chk({t, ".done"}, done[k], eDone);
      chk({t, ".adel"}, adel[k], eAdel);
      chk({t, ".ades"}, ades[k], eAdes);
      chk({t, ".mem_req"}, mem_req[k], eReq);
      chk({t, ".rdata_o"}, rdata_o[k], expRd[k]);
      if (eAdel || eAdes) chk({t, ".badvaddr"}, badvaddr[k], addr);
      if (eReq) begin
         chk({t, ".mem_addr"}, mem_addr[k], mAddr);
         chk({t, ".mem_size"}, mem_size[k], expSize(mOp));
         chk({t, ".mem_wr"}, mem_wr[k], isSt(mOp));
         chk({t, ".mem_wstrb"}, mem_wstrb[k], isSt(mOp) ? expStrb(mOp, mAddr, k == 0) : 4'b0000);
         if (isSt(mOp)) chk({t, ".mem_wdata"}, mem_wdata[k], expWd(mOp, mWd));
      end else begin
         chk({t, ".mem_wstrb_idle"}, mem_wstrb[k], 4'b0000);
      end
   endtask

   initial begin
      bit free, legal, bad, eStall, eDone, eAdel, eAdes, eReq;
      forever begin
         @(negedge clk);
         if (checkEn) begin
            free   = !busy && !finishing;
            legal  = req_valid && isValid(mem_op) && aligned(mem_op, addr);
            bad    = req_valid && isValid(mem_op) && !aligned(mem_op, addr) && !flush;
            eReq   = !rst && busy && !accepted;
            eStall = !rst && ((free && legal && !flush) || (busy && (!cancelled || legal)));
            eDone  = !rst && finishing;
            eAdel  = !rst && free && bad && !isSt(mem_op);
            eAdes  = !rst && free && bad && isSt(mem_op);
            for (int k = 0; k < 2; k++) cmpDut(k, eStall, eDone, eAdel, eAdes, eReq);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int          stallCyc, reqCyc, doneCyc, lat;
   logic [3:0]  capStrb[2];
   logic [31:0] capWd[2];

   // Drives one access from the accept cycle (c=0) to the cycle after done.
   task automatic doAccess(input logic [3:0] op, input logic [31:0] a, wd, rd,
                           input int addrLat, dataLat);
      int c;
      bit fin;
      stallCyc = 0; reqCyc = 0; doneCyc = 0; lat = -1; c = 0; fin = 0;
      capStrb[0] = 4'hx; capStrb[1] = 4'hx; capWd[0] = 'x; capWd[1] = 'x;
      req_valid = 1; mem_op = op; addr = a; wdata = wd; mem_rdata = rd;
      while (!fin && c < 40) begin
         mem_addr_ok = (c == addrLat + 1);
         mem_data_ok = (c == addrLat + 1 + dataLat);
         #3;
         if (stall[0]) stallCyc++;
         if (mem_req[0]) begin
            reqCyc++;
            for (int k = 0; k < 2; k++) begin
               capStrb[k] = mem_wstrb[k];
               capWd[k]   = mem_wdata[k];
            end
         end
         if (done[0]) begin
            doneCyc++;
            lat = c;
            fin = 1;
         end
         tick();
         c++;
      end
      req_valid = 0; mem_op = 0; mem_addr_ok = 0; mem_data_ok = 0;
      chk("access.completed", fin, 1'b1);
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, wd, rd;
      int          aLat, dLat;
      logic [31:0] rdB, rdL;
      logic [3:0]  sB, sL;
      logic [31:0] wdExp;
   } vec_t;

   vec_t vecs[9];

   initial begin
      //           op     addr          wdata         mem_rdata     aL dL rdata BE      rdata LE      strb BE  strb LE  store data
      vecs[0] = '{4'd1, 32'h0000_1001, 32'h0,        32'h1280FF34, 0, 1, 32'hFFFFFF80, 32'hFFFFFFFF, 4'b0000, 4'b0000, 32'h0};
      vecs[1] = '{4'd7, 32'h0000_2002, 32'hABCD1234, 32'h0,        0, 1, 32'h0,        32'h0,        4'b0011, 4'b1100, 32'h12341234};
      vecs[2] = '{4'd2, 32'h0000_1003, 32'h0,        32'h1280FF34, 1, 1, 32'h00000034, 32'h00000012, 4'b0000, 4'b0000, 32'h0};
      vecs[3] = '{4'd3, 32'h0000_1002, 32'h0,        32'h1280FF34, 0, 2, 32'hFFFFFF34, 32'h00001280, 4'b0000, 4'b0000, 32'h0};
      vecs[4] = '{4'd6, 32'h0000_3001, 32'h000000A5, 32'h0,        0, 1, 32'h0,        32'h0,        4'b0100, 4'b0010, 32'hA5A5A5A5};
      vecs[5] = '{4'd6, 32'h0000_3003, 32'h1234567E, 32'h0,        2, 1, 32'h0,        32'h0,        4'b0001, 4'b1000, 32'h7E7E7E7E};
      vecs[6] = '{4'd8, 32'h0000_3000, 32'hCAFEF00D, 32'h0,        0, 1, 32'h0,        32'h0,        4'b1111, 4'b1111, 32'hCAFEF00D};
      vecs[7] = '{4'd4, 32'h0000_4000, 32'h0,        32'h8001FFFF, 4, 2, 32'h00008001, 32'h0000FFFF, 4'b0000, 4'b0000, 32'h0};
      vecs[8] = '{4'd5, 32'h0000_2000, 32'h0,        32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0000, 4'b0000, 32'h0};

      rst = 1; req_valid = 0; mem_op = 0; addr = 0; wdata = 0; flush = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
      tick();
      checkEn = 1;
      tick();
      rst = 0;
      #2;
      chk("reset.rdata_be", rdata_o[0], 32'h0);
      chk("reset.stall", stall[0], 1'b0);
      chk("reset.mem_req", mem_req[1], 1'b0);
      tick();

      for (int i = 0; i < 9; i++) begin
         doAccess(vecs[i].op, vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].aLat, vecs[i].dLat);
         #2;
         chk($sformatf("vec%0d.latency", i), lat, vecs[i].aLat + vecs[i].dLat + 2);
         chk($sformatf("vec%0d.stall_cycles", i), stallCyc, vecs[i].aLat + vecs[i].dLat + 2);
         chk($sformatf("vec%0d.req_cycles", i), reqCyc, vecs[i].aLat + 1);
         chk($sformatf("vec%0d.done_count", i), doneCyc, 1);
         chk($sformatf("vec%0d.strb_be", i), capStrb[0], vecs[i].sB);
         chk($sformatf("vec%0d.strb_le", i), capStrb[1], vecs[i].sL);
         if (isSt(vecs[i].op)) begin
            chk($sformatf("vec%0d.wdata_be", i), capWd[0], vecs[i].wdExp);
            chk($sformatf("vec%0d.wdata_le", i), capWd[1], vecs[i].wdExp);
         end else begin
            chk($sformatf("vec%0d.rdata_be", i), rdata_o[0], vecs[i].rdB);
            chk($sformatf("vec%0d.rdata_le", i), rdata_o[1], vecs[i].rdL);
         end
         tick();
      end

      // misaligned load and store: exception only, no bus activity
      req_valid = 1; mem_op = 4'd5; addr = 32'h3002;
      for (int c = 0; c < 2; c++) begin
         #2;
         chk("misalign_lw.adel", adel[0], 1'b1);
         chk("misalign_lw.badvaddr", badvaddr[1], 32'h3002);
         chk("misalign_lw.stall", stall[0], 1'b0);
         chk("misalign_lw.mem_req", mem_req[0], 1'b0);
         tick();
      end
      mem_op = 4'd7; addr = 32'h2001;
      #2;
      chk("misalign_sh.ades", ades[1], 1'b1);
      chk("misalign_sh.adel", adel[1], 1'b0);
      tick();
      req_valid = 0; mem_op = 0;
      #2;
      chk("misalign.mem_req_after", mem_req[0], 1'b0);
      tick();

      // flush while requesting without address handshake
      req_valid = 1; mem_op = 4'd2; addr = 32'h4401;
      tick();
      req_valid = 0; mem_op = 0; flush = 1;
      #2;
      chk("flush_req.mem_req", mem_req[0], 1'b1);
      tick();
      flush = 0;
      #2;
      chk("flush_req.dropped", mem_req[0], 1'b0);
      chk("flush_req.stall", stall[1], 1'b0);
      tick();

      // flush while waiting for data, then a store that must wait out the drain
      req_valid = 1; mem_op = 4'd5; addr = 32'h5000; mem_rdata = 32'h11111111;
      tick();
      mem_addr_ok = 1;
      tick();
      mem_addr_ok = 0; req_valid = 0; mem_op = 0; flush = 1;
      #2;
      chk("flush_wait.stall", stall[0], 1'b1);
      tick();
      flush = 0; req_valid = 1; mem_op = 4'd8; addr = 32'h6004; wdata = 32'h55AA55AA;
      for (int c = 0; c < 3; c++) begin
         mem_data_ok = (c == 2);
         #2;
         chk("drain.stall", stall[1], 1'b1);
         chk("drain.mem_req", mem_req[0], 1'b0);
         chk("drain.done", done[0], 1'b0);
         chk("drain.rdata_be", rdata_o[0], 32'hDEADBEEF);
         tick();
      end
      mem_data_ok = 0;
      doAccess(4'd8, 32'h6004, 32'h55AA55AA, 32'h0, 0, 1);
      #2;
      chk("after_drain.latency", lat, 3);
      chk("after_drain.strb_be", capStrb[0], 4'b1111);
      chk("after_drain.rdata_le", rdata_o[1], 32'hDEADBEEF);
      tick();

      // reset in the middle of a request
      req_valid = 1; mem_op = 4'd3; addr = 32'h7000;
      tick();
      rst = 1;
      #2;
      chk("rst_req.mem_req_in_rst", mem_req[0], 1'b0);
      chk("rst_req.stall_in_rst", stall[1], 1'b0);
      tick();
      rst = 0; req_valid = 0; mem_op = 0;
      #2;
      chk("rst_req.mem_req", mem_req[0], 1'b0);
      chk("rst_req.stall", stall[0], 1'b0);
      chk("rst_req.rdata_be", rdata_o[0], 32'h0);
      chk("rst_req.rdata_le", rdata_o[1], 32'h0);
      tick();

      doAccess(4'd2, 32'h8002, 32'h0, 32'h11223344, 0, 1);
      #2;
      chk("recover.rdata_be", rdata_o[0], 32'h00000033);
      chk("recover.rdata_le", rdata_o[1], 32'h00000022);
      tick();
      tick();

      checkEn = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 1, meaning byte offset 0 maps to lane 3 (bits 31:24); 0 means offset 0 maps to lane 0 (bits 7:0).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports are clk and rst.
REQ-004 Ports SHALL be (name direction width meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  M-stage holds a memory instruction
- mem_op  in  4  1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; any other value is none
- addr  in  ADDR_W  effective address
- wdata  in  32  unaligned store source (rt value)
- flush  in  1  cancel current M-stage instruction
- stall  out  1  hold pipeline
- done  out  1  one-cycle completion pulse
- rdata_o  out  32  extended load result
- adel  out  1  load address error
- ades  out  1  store address error
- badvaddr  out  ADDR_W  faulting address
- mem_req  out  1  bus request
- mem_wr  out  1  1 means store
- mem_size  out  2  0 byte, 1 half, 2 word
- mem_addr  out  ADDR_W  bus address
- mem_wstrb  out  4  byte strobes
- mem_wdata  out  32  lane-replicated store data
- mem_addr_ok  in  1  request accepted
- mem_data_ok  in  1  data returned or write done
- mem_rdata  in  32  read word

Function
REQ-005 FSM states SHALL be IDLE, REQ, WAIT, DONE, DRAIN.
REQ-006 A legal access is req_valid with a valid mem_op and an aligned address: half accesses need addr[0]=0; word accesses need addr[1:0]=0.
REQ-007 On a legal access in IDLE with flush=0, the unit SHALL latch op, addr and wdata, and go to REQ.
REQ-008 A misaligned access in IDLE SHALL:
- assert adel (load ops) or ades (store ops) combinationally;
- drive badvaddr=addr;
- issue no bus request;
- hold stall=0.
REQ-009 In REQ, mem_req SHALL be 1 with fields taken from the latched values; on mem_addr_ok the FSM SHALL go to WAIT.
REQ-010 In WAIT, on mem_data_ok the FSM SHALL go to DONE; for loads it SHALL register the extracted result into rdata_o on the same edge.
REQ-011 DONE SHALL last one cycle, assert done=1 and stall=0, and then go to IDLE unconditionally; a req_valid seen in DONE SHALL NOT be re-accepted.
REQ-012 stall SHALL be 1 in these cases:
- IDLE accept cycle;
- REQ;
- WAIT;
- DRAIN, while req_valid with a legal op is present.
REQ-013 Minimum latency SHALL be accept at T, mem_req at T+1, mem_data_ok at T+2, done at T+3, giving 3 stall cycles.
REQ-014 The bus contract SHALL be: mem_data_ok arrives no earlier than the cycle after mem_addr_ok, and there is one outstanding request.
REQ-015 Store strobes with BIG_ENDIAN=1 SHALL be:
- SB, offset 0/1/2/3: 1000 / 0100 / 0010 / 0001;
- SH, offset 0/2: 1100 / 0011;
- SW: 1111;
- with BIG_ENDIAN=0, each strobe pattern is bit-reversed.
REQ-016 mem_wdata SHALL be the byte replicated 4x for SB, the halfword replicated 2x for SH, and wdata for SW; loads SHALL drive mem_wstrb=0000 and mem_wr=0.
REQ-017 Loads SHALL select the lane using the same mapping as REQ-015:
- LB/LH sign-extend to 32 bits;
- LBU/LHU zero-extend to 32 bits;
- LW passes the word through.
REQ-018 mem_addr SHALL be the latched address unmodified; mem_size SHALL encode the access width.
REQ-019 flush SHALL act according to state:
- IDLE: suppresses accept.
- REQ without mem_addr_ok: returns to IDLE and drops mem_req next cycle.
- REQ with mem_addr_ok: goes to DRAIN.
- WAIT: goes to DRAIN.
- DONE: ignored.
REQ-020 DRAIN SHALL wait for mem_data_ok, discard the data, not update rdata_o, not pulse done, and then go to IDLE.
REQ-021 When not in REQ, mem_req SHALL be 0 and mem_wstrb SHALL be 0000.

Reset
REQ-022 rst SHALL force state IDLE, rdata_o=0, done=0, the latched op/addr/wdata to 0, and mem_req=0, effective at the next edge, including mid-transaction (a pending mem_data_ok is not tracked).
REQ-023 While rst=1: stall, adel, ades, mem_req and done SHALL be 0.

Verification
REQ-024 LB, addr=0x1001, mem_rdata=0x1280FF34, BIG_ENDIAN=1, addr_ok and data_ok on first opportunity -> stall for 3 cycles, done at T+3, rdata_o=0xFFFFFF80.
REQ-025 SH, addr=0x2002, wdata=0xABCD1234, BIG_ENDIAN=0 -> mem_wstrb=1100, mem_wdata=0x12341234, mem_wr=1, mem_size=1.
REQ-026 LW, addr=0x3002 -> adel=1, badvaddr=0x3002, mem_req never 1, stall=0.
REQ-027 LHU, addr=0x4000, addr_ok delayed 4 cycles, data_ok 2 cycles later, mem_rdata=0x8001FFFF, BIG_ENDIAN=1 -> mem_req held 5 cycles, rdata_o=0x00008001, done exactly once.
REQ-028 Flush in WAIT, then data_ok 3 cycles later -> DRAIN, no done pulse, rdata_o unchanged, and a following SW starts only after the drain.
REQ-029 rst asserted in REQ -> next cycle IDLE, mem_req=0, stall=0, rdata_o=0.
